// File: rtl/alu_cmd_sequencer.sv
// ============================================================================
// alu_cmd_sequencer
// ----------------------------------------------------------------------------
// Issue/capture stage that sits around an external WIDTH-bit ALU and its
// opcode result mux. Commands (opcode + two operands) are buffered in a small
// FIFO. One at a time they are popped into registered alu_* outputs, held
// stable for ALU_LAT cycles, and then the ALU result, carry and overflow are
// captured together with the opcode into a result register offered on a
// valid/ready interface.
//
// Optional feature (compile-time macro ALU_ZERO_FLAG_EN):
//   defined   -> extra output res_zero, registered at capture as
//                (alu_result == 0) and held with the other res_* outputs.
//   undefined -> no res_zero port and no zero-detect logic.
//
// Parameters:
//   DEPTH    command FIFO entries (power of 2, >= 2)
//   ALU_LAT  cycles alu_* are held stable before capture (1..15)
//   WIDTH    operand/result width
//
// Ports:
//   clk, rst_n                         clock (rising edge), async active-low reset
//   cmd_valid/cmd_ready                command handshake (cmd_ready = FIFO not full)
//   cmd_opcode/cmd_a/cmd_b             command fields
//   alu_opcode/alu_a/alu_b             registered command to the ALU
//   alu_result/alu_cout/alu_of         ALU response, sampled at capture
//   res_valid/res_ready                result handshake
//   res_data/res_cout/res_of/res_opcode captured result and the opcode behind it
//   busy                               FSM not idle or FIFO not empty
//   dbg_state                          current FSM state (IDLE=0, WAIT=1, HOLD=2)
//
// Handshakes: a transfer happens on a rising edge where valid && ready are
// both high. The source holds its payload stable while valid is high and not
// yet accepted; ready may not depend on valid. cmd_ready is a function of the
// FIFO fill level only, so it stays low when full even if a pop happens in
// the same cycle.
// ============================================================================
module alu_cmd_sequencer #(
    parameter int DEPTH   = 4,
    parameter int ALU_LAT = 1,
    parameter int WIDTH   = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [3:0]       cmd_opcode,
    input  logic [WIDTH-1:0] cmd_a,
    input  logic [WIDTH-1:0] cmd_b,
    output logic [3:0]       alu_opcode,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    input  logic [WIDTH-1:0] alu_result,
    input  logic             alu_cout,
    input  logic             alu_of,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [WIDTH-1:0] res_data,
    output logic             res_cout,
    output logic             res_of,
    output logic [3:0]       res_opcode,
    output logic             busy,
    output logic [1:0]       dbg_state
`ifdef ALU_ZERO_FLAG_EN
    ,
    output logic             res_zero
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
    localparam logic [3:0]    LAT_M1   = 4'(ALU_LAT - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_HOLD = 2'd2
    } state_e;

    // ------------------------------------------------------------------
    // Command FIFO
    // ------------------------------------------------------------------
    logic [3:0]       op_mem [DEPTH];
    logic [WIDTH-1:0] a_mem  [DEPTH];
    logic [WIDTH-1:0] b_mem  [DEPTH];

    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q,  count_d;

    logic full;
    logic empty;
    logic push;
    logic pop;

    assign full      = (count_q == FULL_CNT);
    assign empty     = (count_q == '0);
    assign cmd_ready = !full;
    assign push      = cmd_valid && !full;

    // Storage has no reset: entries are only read when count_q says they
    // were written since the last reset.
    always_ff @(posedge clk) begin
        if (push) begin
            op_mem[wr_ptr_q] <= cmd_opcode;
            a_mem[wr_ptr_q]  <= cmd_a;
            b_mem[wr_ptr_q]  <= cmd_b;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // ------------------------------------------------------------------
    // Issue / capture FSM
    // ------------------------------------------------------------------
    state_e           state_q,      state_d;
    logic [3:0]       cnt_q,        cnt_d;
    logic [3:0]       alu_opcode_q, alu_opcode_d;
    logic [WIDTH-1:0] alu_a_q,      alu_a_d;
    logic [WIDTH-1:0] alu_b_q,      alu_b_d;
    logic             res_valid_q,  res_valid_d;
    logic [WIDTH-1:0] res_data_q,   res_data_d;
    logic             res_cout_q,   res_cout_d;
    logic             res_of_q,     res_of_d;
    logic [3:0]       res_opcode_q, res_opcode_d;
`ifdef ALU_ZERO_FLAG_EN
    logic             res_zero_q,   res_zero_d;
`endif

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        alu_opcode_d = alu_opcode_q;
        alu_a_d      = alu_a_q;
        alu_b_d      = alu_b_q;
        res_valid_d  = res_valid_q;
        res_data_d   = res_data_q;
        res_cout_d   = res_cout_q;
        res_of_d     = res_of_q;
        res_opcode_d = res_opcode_q;
`ifdef ALU_ZERO_FLAG_EN
        res_zero_d   = res_zero_q;
`endif
        pop          = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (!empty) begin
                    pop          = 1'b1;
                    alu_opcode_d = op_mem[rd_ptr_q];
                    alu_a_d      = a_mem[rd_ptr_q];
                    alu_b_d      = b_mem[rd_ptr_q];
                    // Counts the remaining settle cycles after the pop edge.
                    cnt_d        = LAT_M1;
                    state_d      = S_WAIT;
                end
            end
            S_WAIT: begin
                if (cnt_q == 4'd0) begin
                    res_valid_d  = 1'b1;
                    res_data_d   = alu_result;
                    res_cout_d   = alu_cout;
                    res_of_d     = alu_of;
                    res_opcode_d = alu_opcode_q;
`ifdef ALU_ZERO_FLAG_EN
                    res_zero_d   = (alu_result == '0);
`endif
                    state_d      = S_HOLD;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_HOLD: begin
                if (res_valid_q && res_ready) begin
                    res_valid_d = 1'b0;
                    state_d     = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            alu_opcode_q <= '0;
            alu_a_q      <= '0;
            alu_b_q      <= '0;
            res_valid_q  <= 1'b0;
            res_data_q   <= '0;
            res_cout_q   <= 1'b0;
            res_of_q     <= 1'b0;
            res_opcode_q <= '0;
`ifdef ALU_ZERO_FLAG_EN
            res_zero_q   <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            alu_opcode_q <= alu_opcode_d;
            alu_a_q      <= alu_a_d;
            alu_b_q      <= alu_b_d;
            res_valid_q  <= res_valid_d;
            res_data_q   <= res_data_d;
            res_cout_q   <= res_cout_d;
            res_of_q     <= res_of_d;
            res_opcode_q <= res_opcode_d;
`ifdef ALU_ZERO_FLAG_EN
            res_zero_q   <= res_zero_d;
`endif
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign alu_opcode = alu_opcode_q;
    assign alu_a      = alu_a_q;
    assign alu_b      = alu_b_q;
    assign res_valid  = res_valid_q;
    assign res_data   = res_data_q;
    assign res_cout   = res_cout_q;
    assign res_of     = res_of_q;
    assign res_opcode = res_opcode_q;
`ifdef ALU_ZERO_FLAG_EN
    assign res_zero   = res_zero_q;
`endif
    assign busy       = (state_q != S_IDLE) || !empty;
    assign dbg_state  = state_q;

endmodule
